fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the immediate generator. Produces the `instruction` / `pc` pair that the immediate generator and decoder consume.
- Owns the program counter and issues word fetches to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned words in a small FIFO and presents them downstream with a valid/ready handshake.
- Accepts branch/jump redirects (SB/UJ targets from the execute path) and squashes stale fetches.

---
 rtl/rv32_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/fetch_stage.sv | 158 +++++++++++++++
 tb/tb_fetch_stage.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types and constants used by the fetch stage and its buffers.
package rv32_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned ILEN          = 32;
    localparam int unsigned PC_STEP       = 4;
    localparam int unsigned FETCH_ENTRY_W = XLEN + ILEN;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    // Clear the byte-offset bits of a fetch target.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_stage_if;
    import rv32_pkg::*;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with register-array storage, occupancy count and a dominant flush.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != CW'(0));
    assign head    = mem[rd_ptr];

    // Storage, pointers and count; flush wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC sequencing, imem requests, response buffering and redirects.
// Optional FETCH_MISALIGN_TRAP_EN halts fetch on a misaligned redirect target.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_stage_if.master    imem,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ILEN-1:0]  instruction,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic             misaligned
`endif
);

    localparam int unsigned CW     = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W  = CW + 1;
    localparam int unsigned DROP_W = CW + 3;

    logic              started;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   fetch_pc_nxt;
    logic [DROP_W-1:0] drop_cnt;
    logic [DROP_W-1:0] drop_cnt_nxt;
    logic              halted;

    logic [CW-1:0]     pend_count;
    logic [CW-1:0]     fifo_count;
    logic [XLEN-1:0]   pend_head;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    logic [OCC_W-1:0]  occupancy;
    logic              req_valid_c;
    logic              req_fire;
    logic              in_flight;
    logic              rsp_drop;
    logic              rsp_take;
    logic              rsp_retire;
    logic              out_fire;

    assign occupancy   = OCC_W'(pend_count) + OCC_W'(fifo_count);
    assign req_valid_c = started && !halted && (occupancy < OCC_W'(DEPTH));
    assign req_fire    = req_valid_c && imem.imem_req_ready;

    // Responses retire stale fetches first; with nothing in flight they are ignored.
    assign in_flight  = (drop_cnt != '0) || (pend_count != '0);
    assign rsp_drop   = imem.imem_rsp_valid && (drop_cnt != '0);
    assign rsp_take   = imem.imem_rsp_valid && (drop_cnt == '0) && (pend_count != '0);
    assign rsp_retire = imem.imem_rsp_valid && in_flight;
    assign out_fire   = out_valid && out_ready;

    assign imem.imem_req_valid = req_valid_c;
    assign imem.imem_req_addr  = fetch_pc;

    assign push_entry = '{pc: pend_head, instr: imem.imem_rsp_data};

    // PC sequencing and stale-response accounting; a redirect adds everything still in flight.
    always_comb begin
        fetch_pc_nxt = fetch_pc;
        drop_cnt_nxt = drop_cnt;
        if (redirect_valid) begin
            fetch_pc_nxt = word_align(redirect_pc);
            drop_cnt_nxt = drop_cnt + DROP_W'(pend_count) + DROP_W'(req_fire)
                         - DROP_W'(rsp_retire);
        end else begin
            if (req_fire) begin
                fetch_pc_nxt = fetch_pc + XLEN'(PC_STEP);
            end
            if (rsp_drop) begin
                drop_cnt_nxt = drop_cnt - DROP_W'(1);
            end
        end
    end

    // started delays the first request by a cycle so reset release is clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started  <= 1'b0;
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            started  <= 1'b1;
            fetch_pc <= fetch_pc_nxt;
            drop_cnt <= drop_cnt_nxt;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    fetch_state_e state;
    fetch_state_e state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Every redirect re-decides between running and halting on its low address bits.
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = (redirect_pc[1:0] != 2'b00) ? FETCH_HALT : FETCH_RUN;
        end
    end

    assign halted     = (state == FETCH_HALT);
    assign misaligned = halted;
`else
    assign halted = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pend_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_take),
        .head      (pend_head),
        .count     (pend_count)
    );

    sync_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_take),
        .push_data (push_entry),
        .pop       (out_fire),
        .head      (head_entry),
        .count     (fifo_count)
    );

    // Downstream sees only registered FIFO state; fields read zero while empty.
    assign out_valid   = (fifo_count != '0);
    assign instruction = out_valid ? head_entry.instr : '0;
    assign pc          = out_valid ? head_entry.pc : '0;
    assign pc_plus4    = out_valid ? (head_entry.pc + XLEN'(PC_STEP)) : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order imem model plus program-order scoreboard.
module tb_fetch_stage;
    import rv32_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC (RST_PC),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instruction    (instruction),
        .pc             (pc),
        .pc_plus4       (pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misaligned     (misaligned)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] target;
        int          lat;
        int          pre;
        int          run;
        logic [31:0] exp_first;
        int          min_out;
    } redir_vec_t;

    int           cyc = 0;
    int           lat = 1;
    int           last_due = -1;
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_out = 0;
    int           n_req = 0;
    bit           got_first = 1'b0;
    logic [31:0]  first_pc = '0;
    logic [31:0]  exp_fetch_pc = RST_PC;
    logic [31:0]  mq_addr[$];
    int           mq_due[$];
    fetch_entry_t sb_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: score the pre-edge handshakes, then drive the memory response for the next cycle.
    task automatic step();
        fetch_entry_t e;
        int           d;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (!got_first) begin
                    got_first = 1'b1;
                    first_pc  = pc;
                end
                if (pc == 32'hFFFF_FFFC) check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_out: got pc %08h expected no output (cycle %0d)", pc, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("out_pc", pc, e.pc);
                    check("out_instr", instruction, e.instr);
                    check("out_pc_plus4", pc_plus4, e.pc + 32'd4);
                end
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                n_req++;
                check("req_addr", bus.imem_req_addr, exp_fetch_pc);
                d = cyc + lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mq_addr.push_back(bus.imem_req_addr);
                mq_due.push_back(d);
                if (!redirect_valid) sb_q.push_back('{pc: bus.imem_req_addr, instr: mem_word(bus.imem_req_addr)});
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
            if (redirect_valid) begin
                sb_q.delete();
                exp_fetch_pc = redirect_pc & ~32'h3;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_counts();
        n_out     = 0;
        n_req     = 0;
        got_first = 1'b0;
        first_pc  = '0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
        clear_counts();
    endtask

    task automatic wait_full(input int bound);
        int k = 0;
        while (bus.imem_req_valid && k < bound) begin
            step();
            k++;
        end
    endtask

    task automatic check_first(input string name, input logic [31:0] exp);
        if (!got_first) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no output expected pc %08h (cycle %0d)", name, exp, cyc);
        end else begin
            check(name, first_pc, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        redir_vec_t tbl[4];
        bit         found;

        tbl[0] = '{target: 32'h0000_0200, lat: 3, pre: 6, run: 20, exp_first: 32'h0000_0200, min_out: 4};
        tbl[1] = '{target: 32'hFFFF_FFF8, lat: 1, pre: 4, run: 14, exp_first: 32'hFFFF_FFF8, min_out: 4};
        tbl[2] = '{target: 32'h0000_1000, lat: 2, pre: 4, run: 16, exp_first: 32'h0000_1000, min_out: 4};
        tbl[3] = '{target: 32'h8000_0040, lat: 1, pre: 3, run: 16, exp_first: 32'h8000_0040, min_out: 4};

        rst_n              = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        out_ready          = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;

        // Reset state
        run(3);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_pc_plus4", pc_plus4, 32'd0);
        rst_n = 1'b1;

        // Sequential stream from RESET_PC with single-cycle memory
        clear_counts();
        run(40);
        check_first("stream_first_pc", RST_PC);
        check("stream_rate", 32'(n_out >= 20), 32'd1);

        // Backpressure: two fetches fill DEPTH, head holds
        out_ready = 1'b0;
        do_redirect(RST_PC);
        run(5);
        check("bp_req_count", 32'(n_req), 32'd2);
        check("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head_pc", pc, RST_PC);
        run(2);
        check("bp_hold_pc", pc, RST_PC);
        check("bp_hold_instr", instruction, mem_word(RST_PC));
        out_ready = 1'b1;
        run(10);
        check_first("bp_resume_pc", RST_PC);

        // Redirect table: stale in-flight fetches must never surface
        foreach (tbl[i]) begin
            lat = tbl[i].lat;
            run(tbl[i].pre);
            wait_full(8);
            do_redirect(tbl[i].target);
            run(tbl[i].run);
            check_first("redir_first_pc", tbl[i].exp_first);
            check("redir_min_out", 32'(n_out >= tbl[i].min_out), 32'd1);
        end

        // Redirect in the same cycle as a request acceptance and a response
        lat   = 1;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.imem_req_valid && bus.imem_req_ready && bus.imem_rsp_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("coincide_found", 32'(found), 32'd1);
        do_redirect(32'h0000_0500);
        run(12);
        check_first("coincide_first_pc", 32'h0000_0500);

        // Back-to-back redirects: the second target wins
        lat = 2;
        run(6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0600;
        step();
        redirect_pc    = 32'h0000_0700;
        step();
        redirect_valid = 1'b0;
        clear_counts();
        run(15);
        check_first("b2b_first_pc", 32'h0000_0700);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned target halts fetch until an aligned redirect
        lat = 1;
        do_redirect(32'h0000_0302);
        check("mis_flag_set", 32'(misaligned), 32'd1);
        run(6);
        check("mis_no_req", 32'(n_req), 32'd0);
        check("mis_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("mis_out_valid", 32'(out_valid), 32'd0);
        check("mis_flag_hold", 32'(misaligned), 32'd1);
        do_redirect(32'h0000_0400);
        check("mis_flag_clear", 32'(misaligned), 32'd0);
        run(12);
        check_first("mis_resume_pc", 32'h0000_0400);
`else
        // Low target bits are dropped silently
        lat = 1;
        do_redirect(32'h0000_0302);
        run(12);
        check_first("align_first_pc", 32'h0000_0300);
`endif

        // Reset mid-stream discards buffered and in-flight fetches
        lat = 3;
        run(10);
        rst_n = 1'b0;
        sb_q.delete();
        exp_fetch_pc = RST_PC;
        run(4);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_pc", pc, 32'd0);
        check("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        rst_n = 1'b1;
        clear_counts();
        run(16);
        check_first("midrst_first_pc", RST_PC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
